// File: rtl/alu_decode_issue.sv
// alu_decode_issue: decode RV32 ALU-class fields to an aluControl code behind a 2-entry skid buffer.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     upstream handshake; in_ready is purely registered
//   in_opcode/funct3/     instruction fields [6:0], [14:12], bit 30
//   in_funct7b5
//   in_tag                opaque tag carried through unchanged
//   out_valid/out_ready   downstream handshake toward the ALU stage
//   out_alu_ctrl          ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100
//   out_tag               tag of the presented (oldest) op
//   out_illegal           only with ALU_DEC_ILLEGAL_EN: op was unsupported
//
// Build option: define ALU_DEC_ILLEGAL_EN to add out_illegal and its per-entry storage.
module alu_decode_issue (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [6:0] in_opcode,
  input  logic [2:0] in_funct3,
  input  logic       in_funct7b5,
  input  logic [4:0] in_tag,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_alu_ctrl,
  output logic [4:0] out_tag
`ifdef ALU_DEC_ILLEGAL_EN
  ,
  output logic       out_illegal
`endif
);
  localparam logic [3:0] ADD = 4'b0000;
  localparam logic [3:0] SUB = 4'b0001;
  localparam logic [3:0] AND = 4'b0010;
  localparam logic [3:0] OR  = 4'b0011;
  localparam logic [3:0] XOR = 4'b0100;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  state_t     state_q, state_d;
  logic       in_ready_q;
  logic [3:0] ctrl0_q, ctrl1_q, ctrl0_d, ctrl1_d;
  logic [4:0] tag0_q, tag1_q, tag0_d, tag1_d;
  logic [3:0] raw_ctrl, dec_ctrl;
  logic       dec_hit;
  logic       push, pop;
  logic       ld0_new, ld1_new, shift;
  // Decoder: dec_hit marks a supported opcode/funct3 combination.
  always_comb begin
    raw_ctrl = ADD;
    dec_hit  = 1'b0;
    case (in_opcode)
      7'b0110011: begin
        dec_hit  = (in_funct3 == 3'b000) || (in_funct3 == 3'b111) ||
                   (in_funct3 == 3'b110) || (in_funct3 == 3'b100);
        raw_ctrl = (in_funct3 == 3'b000) ? (in_funct7b5 ? SUB : ADD) :
                   (in_funct3 == 3'b111) ? AND :
                   (in_funct3 == 3'b110) ? OR  :
                   (in_funct3 == 3'b100) ? XOR : ADD;
      end
      7'b0010011: begin
        dec_hit  = (in_funct3 == 3'b000) || (in_funct3 == 3'b111) ||
                   (in_funct3 == 3'b110) || (in_funct3 == 3'b100);
        raw_ctrl = (in_funct3 == 3'b111) ? AND :
                   (in_funct3 == 3'b110) ? OR  :
                   (in_funct3 == 3'b100) ? XOR : ADD;
      end
      7'b0000011, 7'b0100011: begin
        dec_hit  = 1'b1;
        raw_ctrl = ADD;
      end
      7'b1100011: begin
        dec_hit  = 1'b1;
        raw_ctrl = SUB;
      end
      default: begin
        dec_hit  = 1'b0;
        raw_ctrl = ADD;
      end
    endcase
    dec_ctrl = dec_hit ? raw_ctrl : ADD;
  end
  // Handshakes: in_ready is registered, so push never depends on out_ready.
  assign push = in_valid & in_ready_q;
  assign pop  = out_valid & out_ready;
  // Slot 0 is always the oldest entry; slot 1 only fills while slot 0 is stalled.
  assign ld0_new = push & ((state_q == EMPTY) | pop);
  assign ld1_new = push & (state_q == ONE) & ~pop;
  assign shift   = pop & (state_q == TWO);
  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   state_d = push ? ONE : EMPTY;
      ONE:     state_d = (push & ~pop) ? TWO : (~push & pop) ? EMPTY : ONE;
      TWO:     state_d = pop ? ONE : TWO;
      default: state_d = EMPTY;
    endcase
  end
  // Entry datapath
  always_comb begin
    ctrl0_d = ld0_new ? dec_ctrl : shift ? ctrl1_q : ctrl0_q;
    tag0_d  = ld0_new ? in_tag   : shift ? tag1_q  : tag0_q;
    ctrl1_d = ld1_new ? dec_ctrl : ctrl1_q;
    tag1_d  = ld1_new ? in_tag   : tag1_q;
  end
  // State register and entry storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
      ctrl0_q    <= ADD;
      ctrl1_q    <= ADD;
      tag0_q     <= '0;
      tag1_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != TWO);
      ctrl0_q    <= ctrl0_d;
      ctrl1_q    <= ctrl1_d;
      tag0_q     <= tag0_d;
      tag1_q     <= tag1_d;
    end
  end
`ifdef ALU_DEC_ILLEGAL_EN
  logic ill0_q, ill1_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ill0_q <= 1'b0;
      ill1_q <= 1'b0;
    end else begin
      ill0_q <= ld0_new ? ~dec_hit : shift ? ill1_q : ill0_q;
      ill1_q <= ld1_new ? ~dec_hit : ill1_q;
    end
  end
  assign out_illegal = ill0_q;
`endif
  // Outputs
  always_comb begin
    in_ready     = in_ready_q;
    out_valid    = (state_q != EMPTY);
    out_alu_ctrl = ctrl0_q;
    out_tag      = tag0_q;
  end
endmodule

// File: tb/tb_alu_decode_issue.sv
// tb_alu_decode_issue: scoreboard bench for alu_decode_issue.
module tb_alu_decode_issue;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_opcode;
  logic [2:0] in_funct3;
  logic       in_funct7b5;
  logic [4:0] in_tag;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_alu_ctrl;
  logic [4:0] out_tag;
`ifdef ALU_DEC_ILLEGAL_EN
  logic       out_illegal;
`endif
  int tests = 0;
  int fails = 0;
  logic [9:0] sb[$];
  logic [9:0] mon_e;
  alu_decode_issue dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_opcode(in_opcode),
    .in_funct3(in_funct3),
    .in_funct7b5(in_funct7b5),
    .in_tag(in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_alu_ctrl(out_alu_ctrl),
    .out_tag(out_tag)
`ifdef ALU_DEC_ILLEGAL_EN
    ,
    .out_illegal(out_illegal)
`endif
  );
  always #5 clk = ~clk;
  // Directed vectors: opcode, funct3, funct7b5, expected ctrl, expected illegal
  logic [6:0] v_op [16] = '{7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011,
                            7'b0110011, 7'b0010011, 7'b0010011, 7'b0010011,
                            7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                            7'b1101111, 7'b0110011, 7'b0010011, 7'b0110111};
  logic [2:0] v_f3 [16] = '{3'b000, 3'b000, 3'b111, 3'b110, 3'b100, 3'b000, 3'b111, 3'b110,
                            3'b100, 3'b010, 3'b010, 3'b001, 3'b000, 3'b001, 3'b101, 3'b000};
  logic       v_f7 [16] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
                            1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [3:0] v_ec [16] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd2, 4'd3,
                            4'd4, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
  logic       v_ei [16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                            1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Called just after a rising edge; returns just after the edge that sampled the request.
  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic [4:0] tag, input logic [3:0] ec, input logic ei);
    in_valid    = 1'b1;
    in_opcode   = op;
    in_funct3   = f3;
    in_funct7b5 = f7;
    in_tag      = tag;
    @(negedge clk);
    if (in_ready) sb.push_back({ei, ec, tag});
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n       = 1'b1;
    in_valid    = 1'b0;
    in_opcode   = '0;
    in_funct3   = '0;
    in_funct7b5 = 1'b0;
    in_tag      = '0;
    out_ready   = 1'b0;
    // Monitor: every output handshake pops and checks the oldest expectation.
    fork
      forever begin
        @(negedge clk);
        if (rst_n && out_valid && out_ready) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_output: got tag %0d expected no output at %0t", out_tag, $time);
          end else begin
            mon_e = sb.pop_front();
            chk("mon_tag", {27'd0, out_tag}, {27'd0, mon_e[4:0]});
            chk("mon_ctrl", {28'd0, out_alu_ctrl}, {28'd0, mon_e[8:5]});
`ifdef ALU_DEC_ILLEGAL_EN
            chk("mon_illegal", {31'd0, out_illegal}, {31'd0, mon_e[9]});
`endif
          end
        end
      end
    join_none
    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 0);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_ctrl", {28'd0, out_alu_ctrl}, 0);
    chk("rst_tag", {27'd0, out_tag}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 1);
    // Latency-1 SUB decode
    out_ready = 1'b1;
    drive(7'b0110011, 3'b000, 1'b1, 5'd3, 4'd1, 1'b0);
    in_valid = 1'b0;
    chk("lat1_valid", {31'd0, out_valid}, 1);
    chk("lat1_ctrl", {28'd0, out_alu_ctrl}, 1);
    chk("lat1_tag", {27'd0, out_tag}, 3);
    @(posedge clk);
    #1;
    chk("lat1_drained", {31'd0, out_valid}, 0);
    // Fill both entries with the consumer stalled
    out_ready = 1'b0;
    drive(7'b0000011, 3'b010, 1'b0, 5'd1, 4'd0, 1'b0);
    drive(7'b0000011, 3'b010, 1'b0, 5'd2, 4'd0, 1'b0);
    chk("full_in_ready", {31'd0, in_ready}, 0);
    drive(7'b0110011, 3'b100, 1'b0, 5'd4, 4'd4, 1'b0);
    in_valid = 1'b0;
    chk("stall_tag", {27'd0, out_tag}, 1);
    chk("stall_valid", {31'd0, out_valid}, 1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("skid_second_valid", {31'd0, out_valid}, 1);
    chk("skid_second_tag", {27'd0, out_tag}, 2);
    @(posedge clk);
    #1;
    chk("skid_empty", {31'd0, out_valid}, 0);
    chk("skid_sb_empty", sb.size(), 0);
    // Back-to-back stream of every decode case
    for (int i = 0; i < 16; i++) begin
      drive(v_op[i], v_f3[i], v_f7[i], 5'(i + 8), v_ec[i], v_ei[i]);
      chk("stream_in_ready", {31'd0, in_ready}, 1);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("stream_done_valid", {31'd0, out_valid}, 0);
    chk("stream_sb_empty", sb.size(), 0);
    // Asynchronous reset while holding two entries
    out_ready = 1'b0;
    drive(7'b0110011, 3'b111, 1'b0, 5'd20, 4'd2, 1'b0);
    drive(7'b0110011, 3'b110, 1'b0, 5'd21, 4'd3, 1'b0);
    in_valid = 1'b0;
    chk("two_in_ready", {31'd0, in_ready}, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 0);
    chk("arst_in_ready", {31'd0, in_ready}, 0);
    chk("arst_tag", {27'd0, out_tag}, 0);
    chk("arst_ctrl", {28'd0, out_alu_ctrl}, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_in_ready", {31'd0, in_ready}, 1);
    chk("rel_out_valid", {31'd0, out_valid}, 0);
    out_ready = 1'b1;
    drive(7'b0110011, 3'b100, 1'b0, 5'd22, 4'd4, 1'b0);
    in_valid = 1'b0;
    chk("rel_first_tag", {27'd0, out_tag}, 22);
    repeat (3) @(posedge clk);
    #1;
    chk("final_sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_decode_issue.md
ALU_DECODE_ISSUE -- requirements
Module: alu_decode_issue

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port in_valid, input, 1, upstream instruction fields valid.
REQ-004 SHALL have port in_ready, output, 1, block can accept this cycle.
REQ-005 SHALL have port in_opcode, input, 7, instruction bits [6:0].
REQ-006 SHALL have port in_funct3, input, 3, instruction bits [14:12].
REQ-007 SHALL have port in_funct7b5, input, 1, instruction bit 30.
REQ-008 SHALL have port in_tag, input, 5, opaque tag carried to output unchanged.
REQ-009 SHALL have port out_valid, output, 1, decoded op valid toward ALU stage.
REQ-010 SHALL have port out_ready, input, 1, ALU stage accepts this cycle.
REQ-011 SHALL have port out_alu_ctrl, output, 4, ALU operation code driving aluControl.
REQ-012 SHALL have port out_tag, output, 5, tag of the presented op.
REQ-013 SHALL have port out_illegal, output, 1, present only when ALU_DEC_ILLEGAL_EN is defined.

Function
REQ-014 SHALL use ALU codes: ADD 4'b0000, SUB 4'b0001, AND 4'b0010, OR 4'b0011, XOR 4'b0100.
REQ-015 SHALL decode opcode 0110011: funct3 000 -> ADD if funct7b5=0 else SUB; 111 -> AND; 110 -> OR; 100 -> XOR.
REQ-016 SHALL decode opcode 0010011: funct3 000 -> ADD (funct7b5 ignored); 111 -> AND; 110 -> OR; 100 -> XOR.
REQ-017 SHALL decode opcodes 0000011 and 0100011 to ADD; opcode 1100011 to SUB regardless of funct3.
REQ-018 SHALL treat every other opcode/funct3 combination as unsupported: out_alu_ctrl = ADD.
REQ-019 SHALL transfer an input when in_valid & in_ready, and an output when out_valid & out_ready, both sampled on the same rising edge.
REQ-020 SHALL implement a 2-entry in-order skid buffer with states EMPTY, ONE, TWO (entries held).
REQ-021 SHALL drive in_ready = 1 in EMPTY and ONE, 0 in TWO, from registered state only (no combinational path from out_ready).
REQ-022 SHALL drive out_valid = 1 in ONE and TWO, presenting the oldest entry.
REQ-023 SHALL transition: EMPTY+in -> ONE; ONE+in+!out -> TWO; ONE+!in+out -> EMPTY; ONE+in+out -> ONE (new entry presented); TWO+out -> ONE; otherwise hold.
REQ-024 SHALL present an op accepted in EMPTY on out_valid exactly one cycle after acceptance (latency 1).
REQ-025 SHALL keep out_alu_ctrl, out_tag, out_illegal stable while out_valid=1 and out_ready=0.
REQ-026 SHALL ignore in_valid when in_ready=0 and ignore out_ready when out_valid=0.
REQ-027 SHALL never drop, duplicate or reorder ops; tags emerge in acceptance order.

Reset
REQ-028 SHALL, while rst_n=0, force state EMPTY, in_ready=0, out_valid=0, out_alu_ctrl=0, out_tag=0, out_illegal=0, immediately without clock.
REQ-029 SHALL raise in_ready on the first rising edge after rst_n deasserts; ops held at reset assertion are discarded.

Configuration
REQ-030 SHALL, with ALU_DEC_ILLEGAL_EN defined, set out_illegal=1 for entries decoded per REQ-018 and 0 otherwise, stored per entry.
REQ-031 SHALL, without ALU_DEC_ILLEGAL_EN, omit out_illegal and its storage; all other behaviour identical.

Verification
REQ-032 SHALL check: reset, then in opcode 0110011 funct3 000 funct7b5 1 tag 3, out_ready=1 -> next cycle out_valid=1, out_alu_ctrl=0001, out_tag=3.
REQ-033 SHALL check: out_ready=0, push tags 1,2 on consecutive cycles -> in_ready=0 after second; third push ignored; release out_ready -> tags 1 then 2 emitted, one per cycle.
REQ-034 SHALL check: continuous in_valid and out_ready=1 for 16 ops -> one op per cycle, in_ready never falls, tags in order.
REQ-035 SHALL check: opcode 0010011 funct3 000 funct7b5 1 -> 0000; opcode 1100011 funct3 001 -> 0001; opcode 0110011 funct3 110 -> 0011.
REQ-036 SHALL check: opcode 1101111 with ALU_DEC_ILLEGAL_EN -> out_alu_ctrl=0000, out_illegal=1; without macro -> 0000, no port.
REQ-037 SHALL check: rst_n low mid-cycle in state TWO -> out_valid and in_ready fall immediately; after release, first output is a newly pushed op.
